// File: rtl/rsa_io_ctrl_if.sv
// Host bus and engine handshake bundle for the RSA loader/unloader.
// The controller uses the slave view; the board/engine side uses master.
interface rsa_io_ctrl_if #(
    parameter int BUS_W = 32,
    parameter int KEY_W = 64
);
    logic             wr;
    logic             rd;
    logic             key_keep;
    logic [BUS_W-1:0] din;
    logic [BUS_W-1:0] dout;
    logic             eng_start;
    logic [KEY_W-1:0] eng_base;
    logic [KEY_W-1:0] eng_exp;
    logic [KEY_W-1:0] eng_mod;
    logic             eng_done;
    logic [KEY_W-1:0] eng_result;
    logic             io_end;
    logic             busy;
    logic             err;
    logic [1:0]       stage;

    modport slave (
        input  wr, rd, key_keep, din, eng_done, eng_result,
        output dout, eng_start, eng_base, eng_exp, eng_mod, io_end, busy, err, stage
    );

    modport master (
        output wr, rd, key_keep, din, eng_done, eng_result,
        input  dout, eng_start, eng_base, eng_exp, eng_mod, io_end, busy, err, stage
    );
endinterface

// File: rtl/rsa_io_ctrl.sv
// Host-side loader/unloader for the modular-exponentiation engine.
// Assembles base/exponent/modulus from bus words (LSW first), optionally
// reuses a previously loaded key, guards against a zero modulus, starts the
// engine with a one-cycle pulse and hands the result back word by word.
module rsa_io_ctrl #(
    parameter int BUS_W = 32,
    parameter int KEY_W = 64
) (
    input  logic          clk,
    input  logic          rstn,
    rsa_io_ctrl_if.slave  bus
);

    localparam int WORDS  = KEY_W / BUS_W;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               wr_prev_q;
    logic               rd_prev_q;
    logic [1:0]         stage_q;
    logic [WIDX_W-1:0]  widx_q;
    logic [WIDX_W-1:0]  ridx_q;
    logic               keyv_q;
    logic               keep_q;
    logic               err_q;
    logic               start_q;
    logic               io_end_q;
    logic               busy_q;
    logic [KEY_W-1:0]   base_q;
    logic [KEY_W-1:0]   exp_q;
    logic [KEY_W-1:0]   mod_q;
    logic [KEY_W-1:0]   result_q;

    logic               wrPulse;
    logic               rdPulse;
    logic               acceptWrite;
    logic [WIDX_W-1:0]  wordIdx;
    logic [1:0]         wordStage;
    logic               lastWord;
    logic               keepKey;

    // Edge detection and the effective write slot; a write in DONE restarts at base word 0.
    always_comb begin
        wrPulse     = bus.wr & ~wr_prev_q;
        rdPulse     = bus.rd & ~rd_prev_q;
        acceptWrite = wrPulse && ((state_q == LOAD) || (state_q == DONE));
        wordIdx     = (state_q == DONE) ? '0 : widx_q;
        wordStage   = (state_q == DONE) ? 2'd0 : stage_q;
        lastWord    = (wordIdx == LAST_IDX);
        keepKey     = ((wordStage == 2'd0) && (wordIdx == '0)) ? bus.key_keep : keep_q;
    end

    // Single control FSM: operand loading, engine handshake, readback and error tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= LOAD;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            stage_q   <= 2'd0;
            widx_q    <= '0;
            ridx_q    <= '0;
            keyv_q    <= 1'b0;
            keep_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            io_end_q  <= 1'b0;
            busy_q    <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            result_q  <= '0;
        end else begin
            wr_prev_q <= bus.wr;
            rd_prev_q <= bus.rd;
            start_q   <= 1'b0;
            if (acceptWrite) begin
                io_end_q <= 1'b0;
                if ((wordStage == 2'd0) && (wordIdx == '0)) begin
                    keep_q <= bus.key_keep;
                end
                case (wordStage)
                    2'd0:    base_q[wordIdx*BUS_W +: BUS_W] <= bus.din;
                    2'd1:    exp_q[wordIdx*BUS_W +: BUS_W]  <= bus.din;
                    default: mod_q[wordIdx*BUS_W +: BUS_W]  <= bus.din;
                endcase
                if (!lastWord) begin
                    widx_q  <= wordIdx + 1'b1;
                    stage_q <= wordStage;
                    state_q <= LOAD;
                end else begin
                    widx_q <= '0;
                    if ((wordStage == 2'd0) && !(keepKey && keyv_q)) begin
                        stage_q <= 2'd1;
                        state_q <= LOAD;
                    end else if (wordStage == 2'd1) begin
                        stage_q <= 2'd2;
                        state_q <= LOAD;
                    end else begin
                        stage_q <= 2'd3;
                        state_q <= START;
                        if (wordStage == 2'd2) begin
                            keyv_q <= 1'b1;
                        end
                    end
                end
            end else begin
                case (state_q)
                    START: begin
                        if (wrPulse) begin
                            err_q <= 1'b1;
                        end
                        if (mod_q == '0) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            io_end_q <= 1'b1;
                            ridx_q   <= '0;
                            state_q  <= DONE;
                        end else begin
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (wrPulse) begin
                            err_q <= 1'b1;
                        end
                        if (bus.eng_done) begin
                            result_q <= bus.eng_result;
                            ridx_q   <= '0;
                            busy_q   <= 1'b0;
                            io_end_q <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE: begin
                        if (rdPulse) begin
                            ridx_q <= (ridx_q == LAST_IDX) ? '0 : ridx_q + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.dout      = result_q[ridx_q*BUS_W +: BUS_W];
    assign bus.eng_start = start_q;
    assign bus.eng_base  = base_q;
    assign bus.eng_exp   = exp_q;
    assign bus.eng_mod   = mod_q;
    assign bus.io_end    = io_end_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.stage     = stage_q;

endmodule

// File: tb/tb_rsa_io_ctrl.sv
// Self-checking bench for rsa_io_ctrl: directed jobs from the plan plus
// randomized jobs, checked against a job-level model and a behavioural engine.
module tb_rsa_io_ctrl;

    localparam int BUS_W = 32;
    localparam int KEY_W = 64;
    localparam int WORDS = KEY_W / BUS_W;

    logic clk;
    logic rstn;

    rsa_io_ctrl_if #(.BUS_W(BUS_W), .KEY_W(KEY_W)) bus ();

    rsa_io_ctrl #(.BUS_W(BUS_W), .KEY_W(KEY_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    int startCount = 0;
    logic holdOff = 1'b0;
    logic [KEY_W-1:0] snapBase, snapExp, snapMod;

    logic modelKeyv;
    logic modelErr;
    logic modelDone;
    logic [KEY_W-1:0] modelExp, modelMod, prevResult;
    int modelRidx;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [KEY_W-1:0] modExp(input logic [KEY_W-1:0] b,
                                                 input logic [KEY_W-1:0] e,
                                                 input logic [KEY_W-1:0] m);
        logic [127:0] r, x, mm;
        if (m == '0) return '0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        x  = {64'd0, b} % mm;
        for (int i = 0; i < KEY_W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[KEY_W-1:0];
    endfunction

    function automatic logic [BUS_W-1:0] wordOf(input logic [KEY_W-1:0] v, input int i);
        return v[i*BUS_W +: BUS_W];
    endfunction

    function automatic logic [KEY_W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [KEY_W-1:0] got,
                               input logic [KEY_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural engine: snapshots operands at eng_start, answers after a random latency.
    always begin
        @(negedge clk);
        if (bus.eng_start === 1'b1) begin
            startCount++;
            snapBase = bus.eng_base;
            snapExp  = bus.eng_exp;
            snapMod  = bus.eng_mod;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            while (holdOff) @(negedge clk);
            bus.eng_result = modExp(snapBase, snapExp, snapMod);
            bus.eng_done   = 1'b1;
            @(negedge clk);
            bus.eng_done   = 1'b0;
        end
    end

    task automatic writeWord(input logic [BUS_W-1:0] w);
        bus.din = w;
        bus.wr  = 1'b1;
        tick();
        repeat ($urandom_range(0, 2)) begin
            bus.din = $urandom;
            tick();
        end
        bus.wr  = 1'b0;
        bus.din = $urandom;
        tick();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic readPulse();
        bus.rd = 1'b1;
        tick();
        repeat ($urandom_range(0, 1)) tick();
        bus.rd = 1'b0;
        tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dout"},  64'(bus.dout), 64'd0);
        checkOutput({tag, "_start"}, 64'(bus.eng_start), 64'd0);
        checkOutput({tag, "_base"},  bus.eng_base, 64'd0);
        checkOutput({tag, "_exp"},   bus.eng_exp, 64'd0);
        checkOutput({tag, "_mod"},   bus.eng_mod, 64'd0);
        checkOutput({tag, "_ioend"}, 64'(bus.io_end), 64'd0);
        checkOutput({tag, "_busy"},  64'(bus.busy), 64'd0);
        checkOutput({tag, "_err"},   64'(bus.err), 64'd0);
        checkOutput({tag, "_stage"}, 64'(bus.stage), 64'd0);
    endtask

    task automatic modelReset();
        modelKeyv  = 1'b0;
        modelErr   = 1'b0;
        modelDone  = 1'b0;
        modelExp   = '0;
        modelMod   = '0;
        prevResult = '0;
        modelRidx  = 0;
    endtask

    // One complete job: load words, check the start handshake, wait for the result, read it back.
    task automatic applyStimulus(input logic keep, input logic [KEY_W-1:0] base,
                                 input logic [KEY_W-1:0] ex, input logic [KEY_W-1:0] md,
                                 input int rdCount, input bit poke, input bit withRd);
        logic [BUS_W-1:0] words [3*WORDS];
        logic [KEY_W-1:0] mExp, mMod, res;
        bit full, pokeNow;
        int n, startsBefore, c;

        full = !(keep && modelKeyv);
        mExp = full ? ex : modelExp;
        mMod = full ? md : modelMod;
        n    = full ? 3 * WORDS : WORDS;
        for (int i = 0; i < WORDS; i++) begin
            words[i]           = wordOf(base, i);
            words[WORDS + i]   = wordOf(ex, i);
            words[2*WORDS + i] = wordOf(md, i);
        end
        pokeNow      = poke && (mMod != '0);
        holdOff      = pokeNow;
        startsBefore = startCount;
        bus.key_keep = keep;

        for (int j = 0; j < n - 1; j++) begin
            checkOutput("stage_load", 64'(bus.stage), (j == 0 && modelDone) ? 64'd3 : 64'(j / WORDS));
            if (j == 0 && withRd && modelDone) begin
                bus.din = words[0];
                bus.wr  = 1'b1;
                bus.rd  = 1'b1;
                tick();
                checkOutput("rd_vs_wr_dout", 64'(bus.dout), 64'(wordOf(prevResult, modelRidx)));
                bus.wr = 1'b0;
                bus.rd = 1'b0;
                tick();
            end else begin
                writeWord(words[j]);
            end
            if (j == 0) checkOutput("io_end_clear", 64'(bus.io_end), 64'd0);
        end

        checkOutput("no_early_start", 64'(startCount - startsBefore), 64'd0);
        bus.din = words[n-1];
        bus.wr  = 1'b1;
        tick();
        checkOutput("start_early", 64'(bus.eng_start), 64'd0);
        checkOutput("stage_run", 64'(bus.stage), 64'd3);
        tick();
        if (mMod != '0) begin
            checkOutput("start_pulse", 64'(bus.eng_start), 64'd1);
        end else begin
            checkOutput("zero_mod_done", 64'(bus.io_end), 64'd1);
            checkOutput("zero_mod_nostart", 64'(bus.eng_start), 64'd0);
        end
        tick();
        checkOutput("start_len", 64'(bus.eng_start), 64'd0);
        if (mMod != '0) checkOutput("busy_run", 64'(bus.busy), 64'd1);
        bus.wr = 1'b0;
        tick();

        if (pokeNow) begin
            bus.din = $urandom;
            bus.wr  = 1'b1;
            tick();
            bus.wr  = 1'b0;
            tick();
            checkOutput("err_busy", 64'(bus.err), 64'd1);
            checkOutput("base_kept", bus.eng_base, base);
            checkOutput("busy_hold", 64'(bus.busy), 64'd1);
            modelErr = 1'b1;
            holdOff  = 1'b0;
        end

        if (full) begin
            modelExp  = ex;
            modelMod  = md;
            modelKeyv = 1'b1;
        end
        if (mMod == '0) modelErr = 1'b1;
        res = modExp(base, mExp, mMod);

        c = 0;
        while (!bus.io_end && c < 200) begin
            tick();
            c++;
        end
        checkOutput("io_end", 64'(bus.io_end), 64'd1);
        checkOutput("busy_end", 64'(bus.busy), 64'd0);
        checkOutput("start_count", 64'(startCount - startsBefore), (mMod != '0) ? 64'd1 : 64'd0);
        checkOutput("err", 64'(bus.err), 64'(modelErr));
        if (mMod != '0) begin
            checkOutput("eng_base", snapBase, base);
            checkOutput("eng_exp", snapExp, mExp);
            checkOutput("eng_mod", snapMod, mMod);
        end
        for (int i = 0; i <= rdCount; i++) begin
            checkOutput("readback", 64'(bus.dout), 64'(wordOf(res, i % WORDS)));
            if (i < rdCount) readPulse();
        end
        modelRidx  = rdCount % WORDS;
        prevResult = res;
        modelDone  = 1'b1;
    endtask

    initial begin
        rstn           = 1'b0;
        bus.wr         = 1'b0;
        bus.rd         = 1'b0;
        bus.key_keep   = 1'b0;
        bus.din        = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        modelReset();
        repeat (3) tick();
        checkResetState("reset");
        rstn = 1'b1;
        tick();

        applyStimulus(1'b0, 64'd4, 64'd13, 64'd497, 2, 1'b0, 1'b0);
        checkOutput("plan_445", 64'(bus.dout), 64'h1BD);
        applyStimulus(1'b1, 64'd5, 64'hDEAD, 64'hBEEF, 1, 1'b0, 1'b0);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        modelReset();
        applyStimulus(1'b1, rand64(), rand64(), rand64() | 64'd1, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, rand64(), rand64(), rand64() | 64'd1, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, rand64(), rand64(), 64'd0, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, rand64(), rand64(), rand64(), 3, 1'b0, 1'b1);

        for (int k = 0; k < 16; k++) begin
            logic [KEY_W-1:0] md;
            md = ($urandom_range(0, 5) == 0) ? 64'd0 : rand64();
            applyStimulus(1'($urandom_range(0, 1)), rand64(), rand64(), md,
                          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        holdOff      = 1'b1;
        bus.key_keep = 1'b0;
        for (int j = 0; j < 3 * WORDS; j++) writeWord($urandom | 32'd1);
        repeat (2) tick();
        checkOutput("busy_before_rst", 64'(bus.busy), 64'd1);
        rstn = 1'b0;
        #1;
        checkResetState("midreset");
        tick();
        rstn    = 1'b1;
        holdOff = 1'b0;
        modelReset();
        repeat (10) tick();
        checkOutput("spurious_io_end", 64'(bus.io_end), 64'd0);
        checkOutput("spurious_busy", 64'(bus.busy), 64'd0);
        checkOutput("spurious_dout", 64'(bus.dout), 64'd0);
        checkOutput("spurious_stage", 64'(bus.stage), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_io_ctrl.md
# rsa_io_ctrl

Parametrised host-side loader/unloader for the modular-exponentiation engine. Operands wider than the host bus are assembled from successive bus words, and the engine is started with a single-cycle pulse. The result is captured and handed back word by word. Adds three behaviours: multi-word operands, key retention (reload base only), and a zero-modulus guard. Sits between the board-level bus/pushbuttons and the exponentiation core.

## Interface
- BUS_W, 32: host bus width in bits.
- KEY_W, 64: operand/result width in bits; integer multiple of BUS_W, KEY_W/BUS_W = WORDS ≥ 1.
- clk  in  1  system clock, all logic rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- wr  in  1  host write level (debounced externally); rising edge = one write.
- rd  in  1  host read level; rising edge = advance readback word.
- key_keep  in  1  sampled at job start: 1 = reuse stored exponent/modulus.
- din  in  BUS_W  host write data.
- dout  out  BUS_W  current readback word of result.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_base, eng_exp, eng_mod  out  KEY_W  operand registers, stable from eng_start until eng_done.
- eng_done  in  1  one-cycle completion pulse from engine.
- eng_result  in  KEY_W  engine result, valid with eng_done.
- io_end  out  1  result available.
- busy  out  1  engine running.
- err  out  1  sticky error flag.
- stage  out  2  operand being loaded: 0 base, 1 exponent, 2 modulus, 3 none.

## Operation
- Edge detect: wr_d/rd_d registered copies; wr_p = wr & ~wr_d, rd_p = rd & ~rd_d (same-cycle combinational, registered source).
- States: LOAD, START, BUSY, DONE.
- LOAD: each wr_p writes din into word widx of the operand selected by stage, LSW first. widx increments; at widx = WORDS-1 it wraps to 0 and stage advances.
  - Loading starts at stage 0 with widx 0.
  - After the last base word, if key_keep=1 and a key is marked valid (keyv), go to START.
  - Otherwise advance to exponent, then modulus, then go to START.
  - keyv is set at the end of a full load.
- START: if eng_mod == 0, skip the engine: result=0, err=1, go to DONE. Otherwise assert eng_start for exactly one cycle and go to BUSY.
- BUSY: busy=1. On eng_done, capture eng_result into result, set ridx=0, and go to DONE.
- DONE: io_end=1; dout = result word ridx.
  - rd_p increments ridx, wrapping at WORDS-1 to 0 (readback repeats).
  - wr_p starts a new job: widx=0, stage=0, io_end cleared, and that wr_p's din is captured as base word 0 in the same cycle.
- Error conditions: wr_p during START/BUSY is ignored and sets err. rd_p outside DONE is ignored and has no error.
- Simultaneous wr_p and rd_p in DONE: wr_p wins; ridx is not advanced.
- eng_done outside BUSY is ignored.
- err clears only on reset. keyv clears only on reset.

## Timing
- Reset values: dout=0, eng_start=0, eng_base/exp/mod=0, io_end=0, busy=0, err=0, stage=0, widx=0, ridx=0, keyv=0, state LOAD.
- Reset mid-job: everything returns to reset values immediately. The engine is expected to share rstn.
- Write capture: din is sampled at the clk edge where wr=1 and wr_d=0. Holding wr high produces exactly one write.
- Last operand word written at edge k: START at k+1, eng_start=1 during cycle k+1..k+2, busy=1 from k+2.
- eng_done high at edge m: result and io_end valid and busy=0 after edge m. dout shows word 0 after edge m.
- rd_p at edge n: dout shows the next word after edge n.
- stage output reads 3 in START/BUSY/DONE.

## Test plan
- KEY_W=64, BUS_W=32, key_keep=0: write base words 0x00000004, 0, exp 0x0000000D, 0, mod 0x000001F1, 0. Response: one eng_start pulse, eng_base=4, eng_exp=13, eng_mod=497. Model returns 445: io_end=1, dout=0x1BD, after rd dout=0, after second rd dout=0x1BD.
- Key retention: after the above, key_keep=1, write base 0x00000005, 0. Response: eng_start after 2 writes, eng_exp=13 and eng_mod=497 unchanged, stage sequence 0,0,3.
- key_keep=1 straight after reset: keyv=0, so all 6 words are required before eng_start.
- Zero modulus: load mod words 0,0. Response: no eng_start, err=1, io_end=1, dout=0.
- wr pulse while busy: err=1, operands unchanged, job completes normally. Simultaneous wr/rd in DONE: new job starts, din becomes base word 0.
- Assert rstn=0 mid-BUSY, then release with a spurious eng_done: all outputs at reset values, io_end stays 0.
